// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: reprograms MMCME2_ADV CLKOUT0..3 dividers over DRP.
// Define MMCM_DRP_VERIFY_EN to read back and compare every DRP write.
module mmcm_drp_reconfig #(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int DRDY_TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        RST,
  input  logic        cfg_req,
  input  logic [6:0]  cfg_div0,
  input  logic [6:0]  cfg_div1,
  input  logic [6:0]  cfg_div2,
  input  logic [6:0]  cfg_div3,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mmcm_rst,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic [15:0] drp_do,
  input  logic        drdy,
  input  logic        locked
);

  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int DW = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [LW-1:0] LTO = LW'(LOCK_TIMEOUT);
  localparam logic [DW-1:0] DTO = DW'(DRDY_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ASSERT_RST, S_RD, S_RD_WAIT,
    S_WR, S_WR_WAIT, S_RELEASE, S_WAIT_LOCK,
    S_DONE, S_ERROR, S_VRD, S_VRD_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0][6:0] div_q, div_d;
  logic [15:0]     di_q, di_d;
  logic [6:0]      daddr_q, daddr_d;
  logic            mmcm_rst_q, mmcm_rst_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic            lock_meta_q, lock_sync_q;

  logic [6:0]  dsel;
  logic [5:0]  hi, lo;
  logic        edge_b, nocnt;
  logic [15:0] wr_data;
  logic        bad_div, last, d_tmo;
  logic [2:0]  nidx;

  // Divider encoding for the register pair selected by idx.
  always_comb begin
    dsel   = div_q[idx_q[2:1]];
    hi     = dsel[6:1];
    lo     = 6'(dsel - {1'b0, dsel[6:1]});
    edge_b = dsel[0];
    nocnt  = 1'b0;
    if (dsel == 7'd1) begin
      hi     = 6'd1;
      lo     = 6'd1;
      edge_b = 1'b0;
      nocnt  = 1'b1;
    end
    if (idx_q[0])
      wr_data = (drp_do & 16'hFC00) | {8'b0, edge_b, nocnt, 6'b0};
    else
      wr_data = (drp_do & 16'h1000) | {4'b0, hi, lo};
  end

  always_comb begin
    bad_div = 1'b0;
    for (int k = 0; k < 4; k++)
      if (div_q[k] == 7'd0 || div_q[k] == 7'd127)
        bad_div = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    div_d      = div_q;
    di_d       = di_q;
    daddr_d    = daddr_q;
    mmcm_rst_d = mmcm_rst_q;
    err_d      = err_q;
    dcnt_d     = dcnt_q;
    lcnt_d     = lcnt_q;
    last       = (idx_q == 3'd7);
    nidx       = idx_q + 3'd1;
    d_tmo      = (dcnt_q == DTO);
    unique case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          div_d   = {cfg_div3, cfg_div2, cfg_div1, cfg_div0};
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_div) begin
          state_d = S_ERROR;
        end else begin
          mmcm_rst_d = 1'b1;
          state_d    = S_ASSERT_RST;
        end
      end
      S_ASSERT_RST: begin
        idx_d   = 3'd0;
        daddr_d = 7'h08;
        state_d = S_RD;
      end
      S_RD: begin
        dcnt_d  = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drdy) begin
          di_d    = wr_data;
          state_d = S_WR;
        end else if (d_tmo) begin
          state_d = S_ERROR;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_WR: begin
        dcnt_d  = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (drdy) begin
`ifdef MMCM_DRP_VERIFY_EN
          state_d = S_VRD;
`else
          state_d = last ? S_RELEASE : S_RD;
          idx_d   = last ? idx_q : nidx;
          daddr_d = {4'b0001, nidx};
`endif
        end else if (d_tmo) begin
          state_d = S_ERROR;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
`ifdef MMCM_DRP_VERIFY_EN
      S_VRD: begin
        dcnt_d  = '0;
        state_d = S_VRD_WAIT;
      end
      S_VRD_WAIT: begin
        if (drdy) begin
          if (drp_do != di_q) begin
            state_d = S_ERROR;
          end else begin
            state_d = last ? S_RELEASE : S_RD;
            idx_d   = last ? idx_q : nidx;
            daddr_d = {4'b0001, nidx};
          end
        end else if (d_tmo) begin
          state_d = S_ERROR;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
`endif
      S_RELEASE: begin
        lcnt_d  = '0;
        state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_sync_q)
          state_d = S_DONE;
        else if (lcnt_q == LTO)
          state_d = S_ERROR;
        else
          lcnt_d = lcnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Any failure leaves the MMCM released, possibly part-programmed.
    if (state_d == S_ERROR) begin
      err_d      = 1'b1;
      mmcm_rst_d = 1'b0;
    end
    if (state_d == S_RELEASE)
      mmcm_rst_d = 1'b0;
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      div_q       <= '0;
      di_q        <= '0;
      daddr_q     <= '0;
      mmcm_rst_q  <= 1'b0;
      err_q       <= 1'b0;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      di_q        <= di_d;
      daddr_q     <= daddr_d;
      mmcm_rst_q  <= mmcm_rst_d;
      err_q       <= err_d;
      dcnt_q      <= dcnt_d;
      lcnt_q      <= lcnt_d;
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign busy = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign done = (state_q == S_DONE);
  assign den  = (state_q inside {S_RD, S_WR, S_VRD});
  assign dwe  = (state_q == S_WR);
  assign err      = err_q;
  assign mmcm_rst = mmcm_rst_q;
  assign daddr    = daddr_q;
  assign di       = di_q;

endmodule
